// File: rtl/fp_adder_seq.sv
// fp_adder_seq: multi-cycle sign/exponent/fraction adder.
// Works through align, add and normalise states with a start/ready/done
// handshake. Results saturate on exponent overflow and flush to zero on
// underflow.
// Optional build macro FP_ADDER_SEQ_ROUND_EN: carries guard/round/sticky
// bits and adds a round-to-nearest-even state (one extra cycle of latency).
//
// state  | meaning
// IDLE   | ready for a request; sorts and latches operands on start
// ALIGN  | shifts the smaller fraction right one place per cycle
// ADD    | adds or subtracts the aligned fractions
// NORM   | one normalising shift per cycle, detects zero/overflow/underflow
// ROUND  | round-to-nearest-even and renormalise (macro builds only)
// OUT    | result registers just updated, done pulse
module fp_adder_seq #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sign1,
  input  logic              sign2,
  input  logic [EXP_W-1:0]  exp1,
  input  logic [EXP_W-1:0]  exp2,
  input  logic [FRAC_W-1:0] frac1,
  input  logic [FRAC_W-1:0] frac2,
  output logic              ready,
  output logic              done,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              ovf
);

`ifdef FP_ADDER_SEQ_ROUND_EN
  localparam int GB = 3;
`else
  localparam int GB = 0;
`endif
  // Working fraction width: fraction plus any guard/round/sticky bits.
  localparam int XW = FRAC_W + GB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
`ifdef FP_ADDER_SEQ_ROUND_EN
    S_ROUND,
`endif
    S_OUT
  } state_t;

  state_t state, state_n;

  logic              sgn_r;
  logic              eff_sub_r;
  logic [EXP_W-1:0]  exp_r;
  logic [EXP_W-1:0]  diff_r;
  logic [XW-1:0]     big_r;
  logic [XW-1:0]     small_r;
  logic [XW:0]       acc_r;
`ifdef FP_ADDER_SEQ_ROUND_EN
  logic              zero_r;
  logic              ovf_r;
  logic              rnd_up;
  logic [FRAC_W:0]   rnd_sum;
`endif

  // operand sorting
  logic [EXP_W-1:0]  e1, e2, eb, es, diff_raw;
  logic [FRAC_W-1:0] fb, fs;
  logic              sb, op1_big, too_far;
  logic [XW-1:0]     big_ext, small_ext, small_shr;

  // normalise step
  logic [XW:0]       norm_acc;
  logic [EXP_W-1:0]  norm_exp;
  logic              norm_zero, norm_ovf, norm_exit;

  // final result selection
  logic              res_load, res_zero, res_ovf;
  logic [EXP_W-1:0]  res_exp;
  logic [FRAC_W-1:0] res_frac;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and ready decode
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_n = S_ALIGN;
      end
      S_ALIGN: if (diff_r == '0) state_n = S_ADD;
      S_ADD:   state_n = S_NORM;
      S_NORM: begin
`ifdef FP_ADDER_SEQ_ROUND_EN
        if (norm_exit) state_n = S_ROUND;
`else
        if (norm_exit) state_n = S_OUT;
`endif
      end
`ifdef FP_ADDER_SEQ_ROUND_EN
      S_ROUND: state_n = S_OUT;
`endif
      S_OUT:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Sort operands by {exp,frac}; zero operands sort as exponent 0
  always_comb begin
    e1      = (frac1 == '0) ? '0 : exp1;
    e2      = (frac2 == '0) ? '0 : exp2;
    op1_big = {e1, frac1} >= {e2, frac2};
    if (op1_big) begin
      sb = sign1; eb = e1; es = e2; fb = frac1; fs = frac2;
    end else begin
      sb = sign2; eb = e2; es = e1; fb = frac2; fs = frac1;
    end
    diff_raw = eb - es;
    // Beyond FRAC_W+2 places the small operand can only contribute sticky.
    too_far  = int'(diff_raw) > FRAC_W + 2;
    big_ext  = XW'(fb) << GB;
    if (too_far) begin
`ifdef FP_ADDER_SEQ_ROUND_EN
      small_ext = XW'(|fs);
`else
      small_ext = '0;
`endif
    end else begin
      small_ext = XW'(fs) << GB;
    end
  end

  // One-place right shift of the small operand during alignment
  always_comb begin
`ifdef FP_ADDER_SEQ_ROUND_EN
    small_shr = {1'b0, small_r[XW-1:2], small_r[1] | small_r[0]};
`else
    small_shr = small_r >> 1;
`endif
  end

  // One normalisation action on the accumulator
  always_comb begin
    norm_acc  = acc_r;
    norm_exp  = exp_r;
    norm_zero = 1'b0;
    norm_ovf  = 1'b0;
    norm_exit = 1'b1;
    if (acc_r[XW]) begin
      if (&exp_r) begin
        norm_ovf = 1'b1;
      end else begin
`ifdef FP_ADDER_SEQ_ROUND_EN
        norm_acc = {1'b0, acc_r[XW:2], acc_r[1] | acc_r[0]};
`else
        norm_acc = acc_r >> 1;
`endif
        norm_exp = exp_r + 1'b1;
      end
    end else if (acc_r == '0) begin
      norm_zero = 1'b1;
    end else if (!acc_r[XW-1]) begin
      if (exp_r == '0) begin
        norm_zero = 1'b1;
      end else begin
        norm_acc  = acc_r << 1;
        norm_exp  = exp_r - 1'b1;
        norm_exit = 1'b0;
      end
    end
  end

`ifdef FP_ADDER_SEQ_ROUND_EN
  // Round to nearest, ties to even, on the normalised accumulator
  always_comb begin
    rnd_up  = acc_r[2] & (acc_r[1] | acc_r[0] | acc_r[3]);
    rnd_sum = {1'b0, acc_r[XW-1:GB]} + {{FRAC_W{1'b0}}, rnd_up};
  end
`endif

  // Pick the value written to the result registers and when to write it
  always_comb begin
    res_load = 1'b0;
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    res_exp  = norm_exp;
    res_frac = norm_acc[XW-1:GB];
`ifdef FP_ADDER_SEQ_ROUND_EN
    if (state == S_ROUND) begin
      res_load = 1'b1;
      res_zero = zero_r;
      res_ovf  = ovf_r;
      res_exp  = exp_r;
      res_frac = rnd_sum[FRAC_W-1:0];
      if (rnd_sum[FRAC_W]) begin
        // rounding carried out: renormalise by one place
        if (&exp_r) begin
          res_ovf = 1'b1;
        end else begin
          res_exp  = exp_r + 1'b1;
          res_frac = rnd_sum[FRAC_W:1];
        end
      end
    end
`else
    if (state == S_NORM && norm_exit) begin
      res_load = 1'b1;
      res_zero = norm_zero;
      res_ovf  = norm_ovf;
    end
`endif
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sgn_r     <= 1'b0;
      eff_sub_r <= 1'b0;
      exp_r     <= '0;
      diff_r    <= '0;
      big_r     <= '0;
      small_r   <= '0;
      acc_r     <= '0;
`ifdef FP_ADDER_SEQ_ROUND_EN
      zero_r    <= 1'b0;
      ovf_r     <= 1'b0;
`endif
      done      <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      frac_out  <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sgn_r     <= sb;
            eff_sub_r <= sign1 ^ sign2;
            exp_r     <= eb;
            big_r     <= big_ext;
            small_r   <= small_ext;
            diff_r    <= too_far ? '0 : diff_raw;
          end
        end
        S_ALIGN: begin
          if (diff_r != '0) begin
            small_r <= small_shr;
            diff_r  <= diff_r - 1'b1;
          end
        end
        S_ADD: begin
          acc_r <= eff_sub_r ? ({1'b0, big_r} - {1'b0, small_r})
                             : ({1'b0, big_r} + {1'b0, small_r});
        end
        S_NORM: begin
          acc_r <= norm_acc;
          exp_r <= norm_exp;
`ifdef FP_ADDER_SEQ_ROUND_EN
          zero_r <= norm_zero;
          ovf_r  <= norm_ovf;
`endif
        end
        default: ;
      endcase
      if (res_load) begin
        done     <= 1'b1;
        sign_out <= res_zero ? 1'b0 : sgn_r;
        exp_out  <= res_zero ? '0 : (res_ovf ? '1 : res_exp);
        frac_out <= res_zero ? '0 : (res_ovf ? '1 : res_frac);
        ovf      <= res_ovf & ~res_zero;
      end
    end
  end

endmodule

// File: tb/tb_fp_adder_seq.sv
// Directed-vector bench for fp_adder_seq (default parameters).
module tb_fp_adder_seq;
`ifdef FP_ADDER_SEQ_ROUND_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sign1 = 1'b0, sign2 = 1'b0;
  logic [3:0] exp1 = '0, exp2 = '0;
  logic [7:0] frac1 = '0, frac2 = '0;
  logic       ready, done, sign_out, ovf;
  logic [3:0] exp_out;
  logic [7:0] frac_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_adder_seq #(.EXP_W(4), .FRAC_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
    .frac1(frac1), .frac2(frac2),
    .ready(ready), .done(done), .sign_out(sign_out),
    .exp_out(exp_out), .frac_out(frac_out), .ovf(ovf)
  );

  typedef struct {
    logic       s1;
    logic [3:0] e1;
    logic [7:0] f1;
    logic       s2;
    logic [3:0] e2;
    logic [7:0] f2;
    logic       xs;
    logic [3:0] xe;
    logic [7:0] xf;
    logic       xo;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Apply one vector, measure done latency, check result, ready and hold.
  task automatic run_op(input vec_t v, input int repulse, input string tag);
    int  cyc;
    bit  seen;
    bit  extra;
    logic [13:0] want;
    want = {v.xs, v.xe, v.xf, v.xo};
    @(negedge clk);
    sign1 = v.s1; exp1 = v.e1; frac1 = v.f1;
    sign2 = v.s2; exp2 = v.e2; frac2 = v.f2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sign1 = ~v.s1; exp1 = ~v.e1; frac1 = ~v.f1;
    sign2 = ~v.s2; exp2 = ~v.e2; frac2 = v.f1;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      start = (cyc == repulse);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
    end else begin
      check({tag, " latency"}, cyc, v.lat);
      check({tag, " result"}, {sign_out, exp_out, frac_out, ovf}, want);
      @(posedge clk);
      #1;
      check({tag, " ready_after"}, {ready, done}, 2'b10);
      extra = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
        if (done) extra = 1'b1;
      end
      check({tag, " hold"}, {extra, sign_out, exp_out, frac_out, ovf}, {1'b0, want});
    end
  endtask

  initial begin
    bit saw;
    //            s1   e1    f1     s2   e2    f2     xs   xe    xf     xo   lat
    vecs[0]  = '{1'b0, 4'h2, 8'h80, 1'b0, 4'h2, 8'h80, 1'b0, 4'h3, 8'h80, 1'b0, 4 + RL};
    vecs[1]  = '{1'b0, 4'h4, 8'hC0, 1'b0, 4'h2, 8'h80, 1'b0, 4'h4, 8'hE0, 1'b0, 6 + RL};
    vecs[2]  = '{1'b0, 4'h3, 8'h90, 1'b1, 4'h3, 8'h80, 1'b0, 4'h0, 8'h80, 1'b0, 7 + RL};
    vecs[3]  = '{1'b0, 4'h5, 8'hA5, 1'b1, 4'h5, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b0, 4 + RL};
    vecs[4]  = '{1'b0, 4'hF, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b1, 4 + RL};
`ifdef FP_ADDER_SEQ_ROUND_EN
    vecs[5]  = '{1'b0, 4'h1, 8'h81, 1'b0, 4'h0, 8'h81, 1'b0, 4'h1, 8'hC2, 1'b0, 6};
`else
    vecs[5]  = '{1'b0, 4'h1, 8'h81, 1'b0, 4'h0, 8'h81, 1'b0, 4'h1, 8'hC1, 1'b0, 5};
`endif
    vecs[6]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h6, 8'hB0, 1'b1, 4'h6, 8'hB0, 1'b0, 10 + RL};
    vecs[7]  = '{1'b0, 4'hF, 8'h80, 1'b0, 4'h1, 8'hFF, 1'b0, 4'hF, 8'h80, 1'b0, 4 + RL};
    vecs[8]  = '{1'b0, 4'h0, 8'hC0, 1'b1, 4'h0, 8'h80, 1'b0, 4'h0, 8'h00, 1'b0, 4 + RL};
    vecs[9]  = '{1'b1, 4'h4, 8'h90, 1'b0, 4'h2, 8'hC0, 1'b1, 4'h3, 8'hC0, 1'b0, 7 + RL};
    vecs[10] = '{1'b1, 4'h3, 8'hC0, 1'b1, 4'h3, 8'hC0, 1'b1, 4'h4, 8'hC0, 1'b0, 4 + RL};
`ifdef FP_ADDER_SEQ_ROUND_EN
    vecs[11] = '{1'b0, 4'h2, 8'hFF, 1'b0, 4'h0, 8'h81, 1'b0, 4'h3, 8'h90, 1'b0, 7};
    vecs[12] = '{1'b0, 4'hF, 8'hF0, 1'b0, 4'hB, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b1, 9};
    vecs[13] = '{1'b0, 4'h4, 8'hF0, 1'b0, 4'h0, 8'hFF, 1'b0, 4'h5, 8'h80, 1'b0, 9};
`else
    vecs[11] = '{1'b0, 4'h2, 8'hFF, 1'b0, 4'h0, 8'h81, 1'b0, 4'h3, 8'h8F, 1'b0, 6};
    vecs[12] = '{1'b0, 4'hF, 8'hF0, 1'b0, 4'hB, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b0, 8};
    vecs[13] = '{1'b0, 4'h4, 8'hF0, 1'b0, 4'h0, 8'hFF, 1'b0, 4'h4, 8'hFF, 1'b0, 8};
`endif

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready_done", {ready, done}, 2'b10);
    check("reset outputs", {sign_out, exp_out, frac_out, ovf}, 14'h0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i], -1, $sformatf("v%0d", i));
    end

    // start re-pulsed while busy must be ignored
    run_op(vecs[1], 2, "repulse");

    // overflow result followed by a normal add clears ovf
    run_op(vecs[4], -1, "ovf_set");
    run_op(vecs[0], -1, "ovf_clear");

    // reset asserted during ALIGN aborts the operation
    @(negedge clk);
    sign1 = vecs[6].s1; exp1 = vecs[6].e1; frac1 = vecs[6].f1;
    sign2 = vecs[6].s2; exp2 = vecs[6].e2; frac2 = vecs[6].f2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("align busy", ready, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort ready_done", {ready, done}, 2'b10);
    check("abort outputs", {sign_out, exp_out, frac_out, ovf}, 14'h0);
    reset = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) saw = 1'b1;
    end
    check("abort no_done", saw, 1'b0);
    run_op(vecs[0], -1, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
